// File: rtl/gpio_pkg.sv
// gpio_pkg: GPIO widths shared with the pin mux and the per-pin vector type
package gpio_pkg;
    localparam int IOWidth = 36;
    localparam int FiltWidth = 8;
    typedef logic [IOWidth-1:0] gpio_vec_t;
endpackage

// File: rtl/gpio_filt_bit.sv
// gpio_filt_bit: one pin's synchronizer, glitch filter and edge detector
module gpio_filt_bit
    import gpio_pkg::*;
#(
    parameter int LenW = FiltWidth
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            pin,
    input  logic            en,
    input  logic [LenW-1:0] len,
    output logic            level,
    output logic            rise,
    output logic            fall
);
    logic s1, s2, byp, hit, fq_nxt;
    logic [LenW-1:0] cnt, cnt_nxt;
    // cnt >= len also covers len being lowered below an in-flight count
    always_comb begin
        byp = ~en | (len == '0);
        hit = (s2 != level) & (cnt >= len);
        fq_nxt = (byp | hit) ? s2 : level;
        cnt_nxt = (byp | hit | (s2 == level)) ? '0 : cnt + 1'b1;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            level <= 1'b0;
            cnt <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1 <= pin;
            s2 <= s1;
            level <= fq_nxt;
            cnt <= cnt_nxt;
            rise <= fq_nxt & ~level;
            fall <= ~fq_nxt & level;
        end
    end
endmodule

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: per-pin input conditioning with sticky edge flags and interrupt
module gpio_in_filter
    import gpio_pkg::*;
#(
    parameter int IOWidth = gpio_pkg::IOWidth,
    parameter int FiltWidth = gpio_pkg::FiltWidth
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [IOWidth-1:0]   read_data,
    input  logic [IOWidth-1:0]   filt_en,
    input  logic [FiltWidth-1:0] filt_len,
    input  logic [IOWidth-1:0]   rise_en,
    input  logic [IOWidth-1:0]   fall_en,
    input  logic [IOWidth-1:0]   evt_clr,
    output logic [IOWidth-1:0]   filt_data,
    output logic [IOWidth-1:0]   rise_evt,
    output logic [IOWidth-1:0]   fall_evt,
    output logic [IOWidth-1:0]   evt_sticky,
    output logic                 irq
);
    logic [IOWidth-1:0] sticky_nxt;
    for (genvar i = 0; i < IOWidth; i++) begin : g_pin
        gpio_filt_bit #(.LenW(FiltWidth)) u_bit (
            .clk    (clk),
            .reset_n(reset_n),
            .pin    (read_data[i]),
            .en     (filt_en[i]),
            .len    (filt_len),
            .level  (filt_data[i]),
            .rise   (rise_evt[i]),
            .fall   (fall_evt[i])
        );
    end
    // set terms are ORed after the clear so a same-cycle set wins
    always_comb sticky_nxt = (evt_sticky & ~evt_clr) | (rise_evt & rise_en) | (fall_evt & fall_en);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_sticky <= '0;
            irq <= 1'b0;
        end else begin
            evt_sticky <= sticky_nxt;
            irq <= |evt_sticky;
        end
    end
endmodule
